// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: moves the operand one bit per clock for shamt
// clocks, then presents the result on B with a one-cycle done pulse.
module seq_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               A,
    input  logic               R,
    input  logic               L,
    input  logic               drxn,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   B
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               a_q, a_d;
    logic               r_q, r_d;
    logic               l_q, l_d;
    logic               drxn_q, drxn_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   step_v;
    logic               accept;

    // One-position move; the control bits only affect the bit shifted in.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] v,
        input logic             ctl_a,
        input logic             ctl_r,
        input logic             ctl_l,
        input logic             dir_right
    );
        logic fill;
        if (dir_right) begin
            fill = ~ctl_l & ((ctl_r & ~ctl_a & v[0]) | (ctl_a & ~ctl_r & v[WIDTH-1]));
            shift_step = {fill, v[WIDTH-1:1]};
        end else begin
            fill = ctl_r & v[WIDTH-1];
            shift_step = {v[WIDTH-2:0], fill};
        end
    endfunction

    assign step_v = shift_step(work_q, a_q, r_q, l_q, drxn_q);
    assign accept = start && (state_q != SHIFT);

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        r_d     = r_q;
        l_d     = l_q;
        drxn_d  = drxn_q;
        res_d   = res_q;

        case (state_q)
            SHIFT: begin
                work_d = step_v;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = DONE;
                    res_d   = step_v;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Accept is legal in IDLE and DONE, which gives back-to-back issue.
        if (accept) begin
            work_d = b;
            cnt_d  = shamt;
            a_d    = A;
            r_d    = R;
            l_d    = L;
            drxn_d = drxn;
            if (shamt != '0) begin
                state_d = SHIFT;
            end else begin
                state_d = DONE;
                res_d   = b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            r_q     <= 1'b0;
            l_q     <= 1'b0;
            drxn_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            r_q     <= r_d;
            l_q     <= l_d;
            drxn_q  <= drxn_d;
            res_q   <= res_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign B    = res_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit (WIDTH=32): expected results are queued
// at issue time and checked whenever done pulses.
module tb_seq_shift_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] b = '0;
    logic [4:0]  shamt = '0;
    logic        A = 1'b0;
    logic        R = 1'b0;
    logic        L = 1'b0;
    logic        drxn = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] B;

    int tests = 0;
    int failed = 0;
    logic [31:0] sb[$];
    logic [31:0] last_res = '0;

    seq_shift_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .b(b), .shamt(shamt),
        .A(A), .R(R), .L(L), .drxn(drxn),
        .busy(busy), .done(done), .B(B)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Independent whole-shift reference built from shift/rotate operators.
    function automatic logic [31:0] model(input logic [31:0] bv, input logic [4:0] sv,
                                          input logic av, input logic rv,
                                          input logic lv, input logic dv);
        logic [63:0] d;
        logic [31:0] t;
        d = {bv, bv};
        if (dv) begin
            if (!lv && rv && !av) begin
                d = d >> sv;
                t = d[31:0];
            end else if (!lv && av && !rv) begin
                t = $signed(bv) >>> sv;
            end else begin
                t = bv >> sv;
            end
        end else begin
            if (rv) begin
                d = d << sv;
                t = d[63:32];
            end else begin
                t = bv << sv;
            end
        end
        return t;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL done_unexpected: done pulsed with no pending op, B=%h", B);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (B !== e) begin
                    failed++;
                    $display("FAIL result: B=%h expected %h", B, e);
                end
                last_res = e;
            end
        end
    end

    task automatic issue(input logic [31:0] bv, input logic [4:0] sv, input logic av,
                         input logic rv, input logic lv, input logic dv,
                         input logic [31:0] exp, input bit push);
        @(negedge clk);
        b = bv; shamt = sv; A = av; R = rv; L = lv; drxn = dv; start = 1'b1;
        if (push) sb.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        b = $urandom; shamt = 5'($urandom);
        A = 1'($urandom); R = 1'($urandom); L = 1'($urandom); drxn = 1'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL timeout: %0d results still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || B !== 32'h0) begin
            failed++;
            $display("FAIL reset_state: busy=%b done=%b B=%h expected 0 0 00000000", busy, done, B);
        end
        rst = 1'b0;
    endtask

    task automatic test_arith_right();
        issue(32'h80000001, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 32'hF8000000, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            tests++;
            if (busy !== (i <= 4) || done !== (i == 5)) begin
                failed++;
                $display("FAIL arith_timing cycle %0d: busy=%b done=%b expected %b %b",
                         i, busy, done, (i <= 4), (i == 5));
            end
        end
        wait_done();
        repeat (3) @(negedge clk);
        tests++;
        if (B !== 32'hF8000000) begin
            failed++;
            $display("FAIL hold_after_done: B=%h expected F8000000", B);
        end
    endtask

    task automatic test_rotate();
        issue(32'h80000001, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000018, 1'b1);
        wait_done();
        issue(32'h80000001, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hC0000000, 1'b1);
        wait_done();
    endtask

    task automatic test_shamt_zero();
        issue(32'hDEADBEEF, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failed++;
            $display("FAIL shamt0_timing: done=%b busy=%b expected 1 0", done, busy);
        end
        wait_done();
    endtask

    task automatic test_ignore_busy();
        logic [31:0] prev;
        prev = last_res;
        issue(32'h12345678, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1,
              model(32'h12345678, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1), 1'b1);
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b1 || B !== prev) begin
            failed++;
            $display("FAIL hold_in_shift: busy=%b B=%h expected 1 %h", busy, B, prev);
        end
        b = 32'hFFFFFFFF; shamt = 5'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL ignore_start: busy=%b expected 1", busy);
        end
        wait_done();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k;
        issue(32'h0000F00D, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00078068, 1'b1);
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        b = 32'hA5A5A5A5; shamt = 5'd2; A = 1'b1; R = 1'b0; L = 1'b0; drxn = 1'b1;
        start = 1'b1;
        sb.push_back(32'hE9696969);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL back_to_back_accept: busy=%b expected 1", busy);
        end
        wait_done();
    endtask

    task automatic test_reset_mid_shift();
        bit seen;
        issue(32'hCAFEF00D, 5'd20, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (B !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            failed++;
            $display("FAIL async_reset: B=%h busy=%b done=%b expected 00000000 0 0", B, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        last_res = 32'h0;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen || B !== 32'h0) begin
            failed++;
            $display("FAIL abort_no_done: activity=%b B=%h expected 0 00000000", seen, B);
        end
        issue(32'h0F0F0F0F, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 32'hE1E1E1E1, 1'b1);
        wait_done();
    endtask

    task automatic test_logical();
        issue(32'hFFFFFFFF, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000001, 1'b1);
        wait_done();
        issue(32'h80000000, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00800000, 1'b1);
        wait_done();
        issue(32'h80000001, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 32'h08000000, 1'b1);
        wait_done();
        issue(32'h80000001, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000010, 1'b1);
        wait_done();
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [31:0] bv;
            logic [4:0]  sv;
            logic [3:0]  c;
            bv = $urandom;
            sv = 5'($urandom);
            c  = 4'($urandom);
            issue(bv, sv, c[0], c[1], c[2], c[3], model(bv, sv, c[0], c[1], c[2], c[3]), 1'b1);
            wait_done();
        end
    endtask

    initial begin
        test_reset();
        test_arith_right();
        test_rotate();
        test_shamt_zero();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_shift();
        test_logical();
        test_random();
        repeat (5) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seq_shift_unit.md
SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand/result width (>=2).
REQ-002 SHALL have derived parameter: SHAMT_W, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port: clk  input  1  single clock, rising-edge active.
REQ-004 SHALL have port: rst  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port: start  input  1  request to begin an operation.
REQ-006 SHALL have port: b  input  WIDTH  operand.
REQ-007 SHALL have port: shamt  input  SHAMT_W  number of bit positions to shift/rotate (0..WIDTH-1).
REQ-008 SHALL have port: A  input  1  arithmetic control.
REQ-009 SHALL have port: R  input  1  rotate control.
REQ-010 SHALL have port: L  input  1  logical control.
REQ-011 SHALL have port: drxn  input  1  direction, 0 = left, 1 = right.
REQ-012 SHALL have port: busy  output  1  operation in progress, start ignored.
REQ-013 SHALL have port: done  output  1  one-cycle result-valid pulse.
REQ-014 SHALL have port: B  output  WIDTH  registered result.
REQ-015 SHALL use one clock (clk); reset rst SHALL be asynchronous and active-high.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-017 SHALL accept an operation on a rising edge where start=1 and busy=0; SHALL capture b, shamt, A, R, L, drxn into internal registers at that edge.
REQ-018 SHALL, on accept, go to SHIFT if shamt!=0, else DONE.
REQ-019 SHALL, in SHIFT, shift the working register by exactly one position per clock and decrement a down-counter loaded with shamt; SHALL go to DONE on the edge that performs the last (shamt-th) shift.
REQ-020 SHALL, in DONE, assert done=1 for exactly one cycle, then go to IDLE unless a new accept occurs on that edge.
REQ-021 SHALL drive busy=1 only in SHIFT; busy=0 in IDLE and DONE, so a start in the DONE cycle is accepted (back-to-back).
REQ-022 SHALL make done rise in the cycle immediately after the edge that is shamt edges after the accepting edge; total latency accept->done = shamt+1 cycles (shamt=0: done in the next cycle).
REQ-023 SHALL per single step, right (drxn=1): new[i]=old[i+1] for i<WIDTH-1; new[WIDTH-1] = ~L & ((R & ~A & old[0]) | (A & ~R & old[WIDTH-1])).
REQ-024 SHALL per single step, left (drxn=0): new[i]=old[i-1] for i>0; new[0] = R & old[WIDTH-1].
REQ-025 SHALL therefore give: L or no control set -> zero fill; R only -> rotate; A only, right -> sign fill; A only, left -> zero fill; illegal combinations resolve by REQ-023/024 with no error flag.
REQ-026 SHALL update B only on the edge entering DONE; B SHALL hold its value otherwise, including across subsequent IDLE/SHIFT cycles.
REQ-027 SHALL ignore start while busy=1 (no queuing); SHALL ignore changes on b/shamt/A/R/L/drxn after accept.
REQ-028 SHALL treat shamt as unsigned; values >= WIDTH (non-power-of-2 WIDTH) SHALL execute that many single steps.

Reset
REQ-029 SHALL, on rst=1, immediately and asynchronously force state=IDLE, busy=0, done=0, B=0, counter=0, working register=0.
REQ-030 SHALL abort any in-progress operation on reset, with no done pulse and no B update; first accept is possible on the first rising edge after rst deasserts.

Verification (WIDTH=32)
REQ-031 SHALL verify: b=0x80000001, shamt=4, A=1, drxn=1 -> busy high 4 cycles, done 5 cycles after accept, B=0xF8000000.
REQ-032 SHALL verify: b=0x80000001, shamt=4, R=1, drxn=0 -> B=0x00000018; b=0x80000001, R=1, drxn=1, shamt=1 -> B=0xC0000000.
REQ-033 SHALL verify: b=0xDEADBEEF, shamt=0, any mode -> done in the next cycle, busy never high, B=0xDEADBEEF.
REQ-034 SHALL verify: start pulsed during SHIFT with different b -> ignored, first result unchanged; start held high in the DONE cycle -> second op accepted, result correct.
REQ-035 SHALL verify: rst asserted mid-SHIFT (shamt=20, after 5 cycles) -> B=0, busy=0, done never pulses; next op after release completes correctly.
REQ-036 SHALL verify: b=0xFFFFFFFF, L=1, drxn=1, shamt=31 -> B=0x00000001; A=1, L=1, drxn=1 -> zero fill per REQ-023.
